// File: rtl/serial_frame_pkg.sv
// Shared types and helpers for the serial frame sender.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    GAP   = 2'd3
  } state_t;

  // Clock cycles occupied by one complete frame on the serial line.
  function automatic int unsigned frame_cycles(input int unsigned data_width,
                                               input int unsigned gap_bits,
                                               input int unsigned clk_div);
    return (1 + data_width + gap_bits) * clk_div;
  endfunction

endpackage

// File: rtl/serial_frame_sender_fifo.sv
// Show-ahead FIFO with extra-MSB pointers so full and empty are unambiguous.
module sender_fifo
  import serial_frame_pkg::*;
#(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;

  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign level = wptr - rptr;
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full)
        wptr <= wptr + (AW+1)'(1);
      if (pop && !empty)
        rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: pointer reset alone discards the contents.
  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/serial_frame_sender.sv
// Serial frame sender: buffers parallel words and shifts each out as one start
// bit, DATA_WIDTH data bits and GAP_BITS idle bits, one bit per CLK_DIV clocks.
module serial_frame_sender
  import serial_frame_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 40,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CLK_DIV    = 100,
  parameter int unsigned GAP_BITS   = 1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          msb_first,
  output logic                          sout,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned GAP_W    = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam int unsigned GAP_LAST = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;

  state_t                  state;
  logic [DIV_W-1:0]        div_cnt;
  logic                    tick;
  logic [DATA_WIDTH-1:0]   shreg;
  logic [DATA_WIDTH-1:0]   shnext;
  logic                    msb_q;
  logic [CNT_W-1:0]        bitcnt;
  logic [GAP_W-1:0]        gapcnt;
  logic                    sout_q;
  logic                    first_bit;
  logic                    next_bit;
  logic                    last_bit;
  logic                    last_gap;
  logic                    push;
  logic                    pop;
  logic [DATA_WIDTH-1:0]   fifo_rdata;
  logic                    fifo_full;
  logic                    fifo_empty;

  sender_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (in_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready;
  assign sout     = sout_q;
  assign busy     = (state != IDLE);

  // Free-running bit divider; tick marks the last clock of every bit period.
  assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      div_cnt <= '0;
    else if (tick)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + DIV_W'(1);
  end

  assign last_bit = (bitcnt == CNT_W'(DATA_WIDTH - 1));
  assign last_gap = (gapcnt == GAP_W'(GAP_LAST));

  always_comb begin
    shnext    = msb_q ? (shreg << 1) : (shreg >> 1);
    first_bit = msb_q ? shreg[DATA_WIDTH-1] : shreg[0];
    next_bit  = msb_q ? shnext[DATA_WIDTH-1] : shnext[0];
  end

  // A pop on the tick that ends the gap (or the data, with no gap) folds the
  // IDLE visit into that tick, so queued frames follow with no extra idle bit.
  always_comb begin
    pop = 1'b0;
    if (tick && !fifo_empty) begin
      case (state)
        IDLE:    pop = 1'b1;
        DATA:    pop = last_bit && (GAP_BITS == 0);
        GAP:     pop = last_gap;
        default: pop = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      shreg  <= '0;
      msb_q  <= 1'b0;
      bitcnt <= '0;
      gapcnt <= '0;
      sout_q <= IDLE_LEVEL;
    end else if (pop) begin
      shreg  <= fifo_rdata;
      msb_q  <= msb_first;
      sout_q <= ~IDLE_LEVEL;
      state  <= START;
    end else if (tick) begin
      case (state)
        IDLE: ;
        START: begin
          sout_q <= first_bit;
          bitcnt <= '0;
          state  <= DATA;
        end
        DATA: begin
          if (last_bit) begin
            sout_q <= IDLE_LEVEL;
            gapcnt <= '0;
            state  <= (GAP_BITS == 0) ? IDLE : GAP;
          end else begin
            shreg  <= shnext;
            sout_q <= next_bit;
            bitcnt <= bitcnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (last_gap)
            state <= IDLE;
          else
            gapcnt <= gapcnt + GAP_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_sender.sv
// Bench for serial_frame_sender: six parameter sets, each with a frame-level
// reference model and per-cycle comparison, plus hand-computed waveform checks.
module tb_serial_frame_sender;
  import serial_frame_pkg::*;

  localparam int unsigned NCFG = 6;

  function automatic int unsigned cfg_dw(input int unsigned i);
    case (i)
      0, 2:    return 40;
      3:       return 4;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned cfg_div(input int unsigned i);
    case (i)
      0:       return 100;
      1, 4:    return 4;
      2:       return 2;
      3:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic int unsigned cfg_gap(input int unsigned i);
    return (i == 3) ? 0 : 1;
  endfunction

  function automatic int unsigned cfg_il(input int unsigned i);
    return (i == 5) ? 1 : 0;
  endfunction

  logic        clk;
  logic        rst_n_a    [NCFG];
  logic        in_valid_a [NCFG];
  logic        msb_a      [NCFG];
  logic [39:0] in_data_a  [NCFG];

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int g, input string nm,
                     input longint unsigned got, input longint unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL cfg%0d %s: got %0h, expected %0h at %0t", g, nm, got, exp, $time);
    end
  endtask

  for (genvar G = 0; G < NCFG; G++) begin : cfg
    localparam int unsigned DW    = cfg_dw(G);
    localparam int unsigned DIV   = cfg_div(G);
    localparam int unsigned GAPB  = cfg_gap(G);
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;
    localparam logic        IL    = (cfg_il(G) != 0);
    localparam int unsigned FL    = frame_cycles(DW, GAPB, DIV);

    logic          sout_w;
    logic          busy_w;
    logic          rdy_w;
    logic [LW-1:0] lvl_w;

    serial_frame_sender #(
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (DEPTH),
      .CLK_DIV    (DIV),
      .GAP_BITS   (GAPB),
      .IDLE_LEVEL (IL)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n_a[G]),
      .in_data   (in_data_a[G][DW-1:0]),
      .in_valid  (in_valid_a[G]),
      .in_ready  (rdy_w),
      .msb_first (msb_a[G]),
      .sout      (sout_w),
      .busy      (busy_w),
      .level     (lvl_w)
    );

    // Model: queue of words, bit timing from the count of clocks since reset,
    // and the position inside the current frame.
    logic [DW-1:0] q [$];
    logic [DW-1:0] fw;
    bit            fmsb;
    bit            act;
    int unsigned   fpos;
    int unsigned   n;

    initial begin
      int unsigned pre;
      bit          tk;
      q = {};
      fw = '0;
      fmsb = 0;
      act = 0;
      fpos = 0;
      n = 0;
      forever begin
        @(posedge clk or negedge rst_n_a[G]);
        if (!rst_n_a[G]) begin
          q = {};
          act = 0;
          fpos = 0;
          n = 0;
        end else begin
          pre = q.size();
          tk = ((n % DIV) == DIV - 1);
          n++;
          if (act) begin
            fpos++;
            if (fpos == FL) act = 0;
          end
          if (tk && !act && pre != 0) begin
            fw = q.pop_front();
            fmsb = msb_a[G];
            act = 1;
            fpos = 0;
          end
          if (in_valid_a[G] && pre != DEPTH)
            q.push_back(in_data_a[G][DW-1:0]);
        end
      end
    end

    initial begin
      logic        es;
      int unsigned k;
      forever begin
        @(negedge clk);
        if (!act) es = IL;
        else begin
          k = fpos / DIV;
          if (k == 0)       es = !IL;
          else if (k <= DW) es = fmsb ? fw[DW-k] : fw[k-1];
          else              es = IL;
        end
        chk(G, "sout", 64'(sout_w), 64'(es));
        chk(G, "busy", 64'(busy_w), 64'(act));
        chk(G, "level", 64'(lvl_w), 64'(q.size()));
        chk(G, "in_ready", 64'(rdy_w), 64'(q.size() != DEPTH));
      end
    end
  end

  task automatic t_default();
    int unsigned cnt;
    logic [8:0]  rec = '0;
    @(negedge clk);
    chk(0, "idle sout", 64'(cfg[0].sout_w), 0);
    chk(0, "idle level", 64'(cfg[0].lvl_w), 0);
    msb_a[0] = 1'b0;
    in_data_a[0] = 40'hD999999991;
    in_valid_a[0] = 1'b1;
    @(negedge clk);
    in_valid_a[0] = 1'b0;
    cnt = 0;
    while (!cfg[0].busy_w && cnt < 300) begin @(negedge clk); cnt++; end
    chk(0, "start latency bounded", 64'(cnt <= 101), 1);
    cnt = 0;
    while (cfg[0].busy_w && cnt < 5000) begin
      if (cnt % 100 == 50 && cnt < 900) rec = {cfg[0].sout_w, rec[8:1]};
      @(negedge clk);
      cnt++;
    end
    chk(0, "busy cycles", 64'(cnt), 4200);
    chk(0, "start+first 8 bits", 64'(rec), 64'h123);
    chk(0, "sout after frame", 64'(cfg[0].sout_w), 0);
  endtask

  task automatic t_msb();
    int unsigned cnt;
    logic [9:0]  rec = '0;
    msb_a[1] = 1'b1;
    in_data_a[1] = 40'hA5;
    in_valid_a[1] = 1'b1;
    @(negedge clk);
    in_valid_a[1] = 1'b0;
    cnt = 0;
    while (!cfg[1].busy_w && cnt < 50) begin @(negedge clk); cnt++; end
    cnt = 0;
    while (cfg[1].busy_w && cnt < 200) begin
      if (cnt % 4 == 2 && cnt < 40) rec = {cfg[1].sout_w, rec[9:1]};
      if (cnt == 14) msb_a[1] = 1'b0;
      @(negedge clk);
      cnt++;
    end
    chk(1, "busy cycles", 64'(cnt), 40);
    chk(1, "msb-first frame", 64'(rec), 64'h14B);
  endtask

  task automatic t_fill();
    int unsigned idx = 0;
    int unsigned pre_block = 0;
    bit          blocked = 0;
    bit          acc;
    in_valid_a[2] = 1'b1;
    fork
      begin
        int unsigned hi = 0;
        int unsigned fall = 0;
        bit          prev = 0;
        repeat (700) begin
          @(negedge clk);
          if (cfg[2].busy_w) hi++;
          if (prev && !cfg[2].busy_w) fall++;
          prev = cfg[2].busy_w;
        end
        chk(2, "busy cycles over 6 frames", 64'(hi), 504);
        chk(2, "busy falling edges", 64'(fall), 1);
      end
      begin
        for (int cyc = 0; cyc < 400 && idx < 6; cyc++) begin
          in_data_a[2] = {8'(idx), 24'h5A3C96, 8'(8'hF0 ^ 8'(idx))};
          acc = cfg[2].rdy_w;
          if (!acc && !blocked) begin
            blocked = 1;
            pre_block = idx;
            chk(2, "level at stall", 64'(cfg[2].lvl_w), 4);
          end
          @(negedge clk);
          if (acc) idx++;
        end
        in_valid_a[2] = 1'b0;
        chk(2, "accepted before stall", 64'(pre_block), 5);
        chk(2, "accepted total", 64'(idx), 6);
      end
    join
  endtask

  task automatic t_nogap();
    int unsigned cnt;
    int unsigned bh = 0;
    logic [11:0] rec = '0;
    in_data_a[3] = 40'hF;
    in_valid_a[3] = 1'b1;
    @(negedge clk);
    in_data_a[3] = 40'h0;
    @(negedge clk);
    in_valid_a[3] = 1'b0;
    cnt = 0;
    while (!cfg[3].busy_w && cnt < 20) begin @(negedge clk); cnt++; end
    repeat (12) begin
      rec = {cfg[3].sout_w, rec[11:1]};
      if (cfg[3].busy_w) bh++;
      @(negedge clk);
    end
    chk(3, "no-gap sequence", 64'(rec), 64'h03F);
    chk(3, "busy cycles", 64'(bh), 10);
  endtask

  task automatic t_reset();
    int unsigned cnt;
    int unsigned hi = 0;
    int unsigned act = 0;
    in_valid_a[4] = 1'b1;
    in_data_a[4] = 40'h11;
    @(negedge clk);
    in_data_a[4] = 40'h22;
    @(negedge clk);
    in_data_a[4] = 40'h33;
    @(negedge clk);
    in_valid_a[4] = 1'b0;
    cnt = 0;
    while (!cfg[4].busy_w && cnt < 20) begin @(negedge clk); cnt++; end
    repeat (14) @(negedge clk);
    chk(4, "level mid-frame", 64'(cfg[4].lvl_w), 2);
    #2 rst_n_a[4] = 1'b0;
    #1;
    chk(4, "reset sout", 64'(cfg[4].sout_w), 0);
    chk(4, "reset busy", 64'(cfg[4].busy_w), 0);
    chk(4, "reset level", 64'(cfg[4].lvl_w), 0);
    chk(4, "reset in_ready", 64'(cfg[4].rdy_w), 1);
    @(negedge clk);
    rst_n_a[4] = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (cfg[4].busy_w) hi++;
      if (cfg[4].sout_w) act++;
    end
    chk(4, "busy after reset", 64'(hi), 0);
    chk(4, "sout activity after reset", 64'(act), 0);
    in_data_a[4] = 40'h3C;
    in_valid_a[4] = 1'b1;
    @(negedge clk);
    in_valid_a[4] = 1'b0;
    cnt = 0;
    while (!cfg[4].busy_w && cnt < 10) begin @(negedge clk); cnt++; end
    chk(4, "frame after new push", 64'(cfg[4].busy_w), 1);
    repeat (45) @(negedge clk);
  endtask

  task automatic t_idlehigh();
    int unsigned cnt;
    logic [9:0]  rec = '0;
    @(negedge clk);
    chk(5, "idle sout high", 64'(cfg[5].sout_w), 1);
    in_data_a[5] = 40'h00;
    in_valid_a[5] = 1'b1;
    @(negedge clk);
    in_valid_a[5] = 1'b0;
    cnt = 0;
    while (!cfg[5].busy_w && cnt < 20) begin @(negedge clk); cnt++; end
    cnt = 0;
    while (cfg[5].busy_w && cnt < 100) begin
      if (cnt % 3 == 1 && cnt < 30) rec = {cfg[5].sout_w, rec[9:1]};
      @(negedge clk);
      cnt++;
    end
    chk(5, "busy cycles", 64'(cnt), 30);
    chk(5, "idle-high frame", 64'(rec), 64'h200);
    chk(5, "sout after frame", 64'(cfg[5].sout_w), 1);
  endtask

  initial begin
    for (int i = 0; i < NCFG; i++) begin
      rst_n_a[i] = 1'b0;
      in_valid_a[i] = 1'b0;
      msb_a[i] = 1'b0;
      in_data_a[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NCFG; i++) rst_n_a[i] = 1'b1;
    fork
      t_default();
      t_msb();
      t_fill();
      t_nogap();
      t_reset();
      t_idlehigh();
    join
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
